// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, data-memory freeze FSM.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rtaddr_i,
   input  logic [4:0]       ifid_rsaddr_i,
   input  logic [4:0]       ifid_rtaddr_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic             ifid_stall_o,
   output logic             ifid_flush_o,
   output logic             idex_stall_o,
   output logic             idex_bubble_o,
   output logic             exmem_stall_o,
   output logic             memwb_bubble_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   state_e     r_state, w_state_nxt;
   logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
   logic       r_timeout;
   logic       w_load_use, w_mem_hold;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= StRun;
         r_wait_cnt <= 8'd0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         // Sticky: the FSM keeps waiting, the flag only reports the overrun
         if (r_state == StMemWait && r_wait_cnt == 8'(MEM_TIMEOUT)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      unique case (r_state)
         StRun: begin
            if (dmem_req_i && !dmem_ack_i) begin
               w_state_nxt    = StMemWait;
               w_wait_cnt_nxt = 8'd1;
            end
         end
         StMemWait: begin
            if (dmem_ack_i) begin
               w_state_nxt    = StRun;
               w_wait_cnt_nxt = 8'd0;
            end else if (r_wait_cnt != 8'hFF) begin
               w_wait_cnt_nxt = r_wait_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt    = StRun;
            w_wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   assign w_load_use = idex_memread_i && (idex_rtaddr_i != 5'd0) &&
                       ((idex_rtaddr_i == ifid_rsaddr_i) || (idex_rtaddr_i == ifid_rtaddr_i));
   assign w_mem_hold = (r_state == StMemWait && !dmem_ack_i) ||
                       (r_state == StRun && dmem_req_i && !dmem_ack_i);

   always_comb begin
      pc_write_o     = 1'b1;
      ifid_stall_o   = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_stall_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      exmem_stall_o  = 1'b0;
      memwb_bubble_o = 1'b0;
      if (!rst_i) begin
         if (w_mem_hold) begin
            pc_write_o     = 1'b0;
            ifid_stall_o   = 1'b1;
            idex_stall_o   = 1'b1;
            exmem_stall_o  = 1'b1;
            memwb_bubble_o = 1'b1;
         end else if (w_load_use) begin
            pc_write_o    = 1'b0;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
         end else if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
         end
      end
   end

   assign mem_timeout_o = r_timeout;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!pc_write_o && r_stall_cnt != {CNT_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (ifid_flush_o && r_flush_cnt != {CNT_W{1'b1}}) begin
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
// Counter expectations follow HAZARD_PERF_EN: real counts when defined, zero otherwise.
module tb_hazard_stall_ctrl;

   localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall, memwb_bubble}
   localparam logic [6:0] IDLE = 7'b1000000;
   localparam logic [6:0] HOLD = 7'b0101011;
   localparam logic [6:0] LU   = 7'b0100100;
   localparam logic [6:0] BR   = 7'b1010000;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             idex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
   logic [4:0]       idex_rtaddr_i, ifid_rsaddr_i, ifid_rtaddr_i;
   logic             pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o;
   logic             idex_bubble_o, exmem_stall_o, memwb_bubble_o, mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic [6:0]       ctl;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   assign ctl = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_stall_o,
                 idex_bubble_o, exmem_stall_o, memwb_bubble_o};

   hazard_stall_ctrl #(
      .MEM_TIMEOUT(4),
      .CNT_W      (CNT_W)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .idex_memread_i(idex_memread_i),
      .idex_rtaddr_i (idex_rtaddr_i),
      .ifid_rsaddr_i (ifid_rsaddr_i),
      .ifid_rtaddr_i (ifid_rtaddr_i),
      .branch_taken_i(branch_taken_i),
      .dmem_req_i    (dmem_req_i),
      .dmem_ack_i    (dmem_ack_i),
      .pc_write_o    (pc_write_o),
      .ifid_stall_o  (ifid_stall_o),
      .ifid_flush_o  (ifid_flush_o),
      .idex_stall_o  (idex_stall_o),
      .idex_bubble_o (idex_bubble_o),
      .exmem_stall_o (exmem_stall_o),
      .memwb_bubble_o(memwb_bubble_o),
      .mem_timeout_o (mem_timeout_o),
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
   );

   task automatic clr_inputs();
      idex_memread_i = 1'b0;
      idex_rtaddr_i  = 5'd0;
      ifid_rsaddr_i  = 5'd0;
      ifid_rtaddr_i  = 5'd0;
      branch_taken_i = 1'b0;
      dmem_req_i     = 1'b0;
      dmem_ack_i     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst_i          = 1'b1;
      // Hazard inputs active during reset must not leak through
      idex_memread_i = 1'b1;
      idex_rtaddr_i  = 5'd8;
      ifid_rsaddr_i  = 5'd8;
      dmem_req_i     = 1'b1;
      branch_taken_i = 1'b1;
      #2;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL reset_forced: got %b want %b", ctl, IDLE);
      end
      step();
      checks++;
      if (mem_timeout_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
         failures++;
         $display("FAIL reset_regs: got to=%b sc=%0d fc=%0d want 0/0/0",
                  mem_timeout_o, stall_cnt_o, flush_cnt_o);
      end
      clr_inputs();
      rst_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL reset_release_idle: got %b want %b", ctl, IDLE);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      idex_memread_i = 1'b1; idex_rtaddr_i = 5'd8; ifid_rsaddr_i = 5'd8; ifid_rtaddr_i = 5'd3;
      #1;
      checks++;
      if (ctl !== LU) begin
         failures++; $display("FAIL load_use_rs: got %b want %b", ctl, LU);
      end
      step();
      idex_memread_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL load_use_one_cycle: got %b want %b", ctl, IDLE);
      end
      idex_memread_i = 1'b1; idex_rtaddr_i = 5'd17; ifid_rsaddr_i = 5'd2; ifid_rtaddr_i = 5'd17;
      #1;
      checks++;
      if (ctl !== LU) begin
         failures++; $display("FAIL load_use_rt: got %b want %b", ctl, LU);
      end
      step();
      idex_rtaddr_i = 5'd0; ifid_rsaddr_i = 5'd0; ifid_rtaddr_i = 5'd0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL load_use_r0: got %b want %b", ctl, IDLE);
      end
      idex_memread_i = 1'b0; idex_rtaddr_i = 5'd8; ifid_rsaddr_i = 5'd8;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL load_use_no_load: got %b want %b", ctl, IDLE);
      end
      checks++;
      if (stall_cnt_o !== (PERF ? 16'd2 : 16'd0)) begin
         failures++;
         $display("FAIL load_use_stall_cnt: got %0d want %0d", stall_cnt_o, PERF ? 2 : 0);
      end
      clr_inputs();
   endtask

   task automatic test_branch();
      do_reset();
      branch_taken_i = 1'b1;
      #1;
      checks++;
      if (ctl !== BR || flush_cnt_o !== '0) begin
         failures++;
         $display("FAIL branch_flush: got %b fc=%0d want %b fc=0", ctl, flush_cnt_o, BR);
      end
      step();
      branch_taken_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL branch_one_cycle: got %b want %b", ctl, IDLE);
      end
      checks++;
      if (flush_cnt_o !== (PERF ? 16'd1 : 16'd0) || stall_cnt_o !== '0) begin
         failures++;
         $display("FAIL branch_counts: got fc=%0d sc=%0d want fc=%0d sc=0",
                  flush_cnt_o, stall_cnt_o, PERF ? 1 : 0);
      end
   endtask

   task automatic test_mem_wait();
      do_reset();
      dmem_req_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctl !== HOLD) begin
            failures++; $display("FAIL mem_wait_hold%0d: got %b want %b", i, ctl, HOLD);
         end
         step();
      end
      dmem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL mem_wait_ack_cycle: got %b want %b", ctl, IDLE);
      end
      step();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL mem_wait_back_to_run: got %b want %b", ctl, IDLE);
      end
      // Zero-wait access must neither stall nor enter the wait state
      dmem_req_i = 1'b1; dmem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL zero_wait: got %b want %b", ctl, IDLE);
      end
      step();
      dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL zero_wait_stays_run: got %b want %b", ctl, IDLE);
      end
      checks++;
      if (stall_cnt_o !== (PERF ? 16'd3 : 16'd0) || mem_timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL mem_wait_stall_cnt: got sc=%0d to=%b want sc=%0d to=0",
                  stall_cnt_o, mem_timeout_o, PERF ? 3 : 0);
      end
   endtask

   task automatic test_priority();
      do_reset();
      dmem_req_i = 1'b1;
      step();
      idex_memread_i = 1'b1; idex_rtaddr_i = 5'd8; ifid_rsaddr_i = 5'd8; branch_taken_i = 1'b1;
      #1;
      checks++;
      if (ctl !== HOLD) begin
         failures++; $display("FAIL prio_mem_hold: got %b want %b", ctl, HOLD);
      end
      step();
      // Hold releases on the ack cycle, so the pending load-use takes over; branch stays masked
      dmem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl !== LU) begin
         failures++; $display("FAIL prio_load_use_after_ack: got %b want %b", ctl, LU);
      end
      step();
      idex_memread_i = 1'b0; dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
      #1;
      checks++;
      if (ctl !== BR) begin
         failures++; $display("FAIL prio_branch_last: got %b want %b", ctl, BR);
      end
      checks++;
      if (flush_cnt_o !== '0) begin
         failures++; $display("FAIL prio_no_masked_flush: got %0d want 0", flush_cnt_o);
      end
      clr_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      dmem_req_i = 1'b1;
      step();
      dmem_req_i = 1'b0;  // dropped req in the wait state is ignored
      step(); step(); step();
      checks++;
      if (mem_timeout_o !== 1'b0 || ctl !== HOLD) begin
         failures++;
         $display("FAIL timeout_early: got to=%b ctl=%b want to=0 ctl=%b", mem_timeout_o, ctl, HOLD);
      end
      step();
      checks++;
      if (mem_timeout_o !== 1'b1 || ctl !== HOLD) begin
         failures++;
         $display("FAIL timeout_set: got to=%b ctl=%b want to=1 ctl=%b", mem_timeout_o, ctl, HOLD);
      end
      step(); step();
      checks++;
      if (mem_timeout_o !== 1'b1 || ctl !== HOLD) begin
         failures++;
         $display("FAIL timeout_sticky: got to=%b ctl=%b want to=1 ctl=%b", mem_timeout_o, ctl, HOLD);
      end
      dmem_ack_i = 1'b1;
      #1;
      checks++;
      if (ctl !== IDLE) begin
         failures++; $display("FAIL timeout_ack: got %b want %b", ctl, IDLE);
      end
      step();
      dmem_ack_i = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE || mem_timeout_o !== 1'b1) begin
         failures++;
         $display("FAIL timeout_run_after_ack: got ctl=%b to=%b want ctl=%b to=1",
                  ctl, mem_timeout_o, IDLE);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      dmem_req_i = 1'b1;
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (ctl !== HOLD || mem_timeout_o !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: got ctl=%b to=%b want ctl=%b to=1", ctl, mem_timeout_o, HOLD);
      end
      #2;
      rst_i          = 1'b1;
      idex_memread_i = 1'b1; idex_rtaddr_i = 5'd8; ifid_rsaddr_i = 5'd8;
      #1;
      checks++;
      if (ctl !== IDLE || mem_timeout_o !== 1'b0 || stall_cnt_o !== '0) begin
         failures++;
         $display("FAIL rst_mid_async: got ctl=%b to=%b sc=%0d want ctl=%b to=0 sc=0",
                  ctl, mem_timeout_o, stall_cnt_o, IDLE);
      end
      step();
      rst_i = 1'b0;
      clr_inputs();
      #1;
      checks++;
      if (ctl !== IDLE || mem_timeout_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
         failures++;
         $display("FAIL rst_mid_release: got ctl=%b to=%b sc=%0d fc=%0d want ctl=%b zeros",
                  ctl, mem_timeout_o, stall_cnt_o, flush_cnt_o, IDLE);
      end
   endtask

   initial begin
      clr_inputs();
      #1;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_priority();
      test_timeout();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline hazard/stall controller for the 5-stage MIPS datapath.
- Produces the hold, bubble and flush controls consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Its idex_stall_o drives the ID/EX register's stall input.
- Resolves three hazards: load-use hazards (1-cycle bubble), taken-branch flushes, and multi-cycle data-memory waits (freeze FSM with timeout detection).

Parameters:
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before mem_timeout_o sets (legal 2..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- idex_memread_i  in  1  ID/EX stage holds a load
- idex_rtaddr_i  in  5  load destination register in ID/EX
- ifid_rsaddr_i  in  5  rs field of the instruction in IF/ID
- ifid_rtaddr_i  in  5  rt field of the instruction in IF/ID
- branch_taken_i  in  1  branch resolved taken in ID
- dmem_req_i  in  1  EX/MEM instruction accesses data memory this cycle
- dmem_ack_i  in  1  data memory completes the access this cycle
- pc_write_o  out  1  PC update enable
- ifid_stall_o  out  1  IF/ID hold
- ifid_flush_o  out  1  IF/ID load NOP
- idex_stall_o  out  1  ID/EX hold
- idex_bubble_o  out  1  zero the ID/EX control fields
- exmem_stall_o  out  1  EX/MEM hold
- memwb_bubble_o  out  1  zero the MEM/WB RegWrite/MemtoReg fields
- mem_timeout_o  out  1  sticky memory-timeout error flag
- stall_cnt_o  out  CNT_W  cycles spent in any stall (optional)
- flush_cnt_o  out  CNT_W  number of flushes (optional)

Behaviour:
- FSM states: RUN, MEM_WAIT. The state register, wait counter (8-bit), mem_timeout_o and the perf counters are the only flops; all other outputs are combinational from state and inputs.
- Reset (async, rst_i high): state=RUN, wait counter=0, mem_timeout_o=0, counters=0.
- While rst_i is high, outputs are forced to: pc_write_o=1, all stall/bubble/flush outputs 0.
- load_use = idex_memread_i && idex_rtaddr_i!=0 && (idex_rtaddr_i==ifid_rsaddr_i || idex_rtaddr_i==ifid_rtaddr_i).
- mem_hold = (state==MEM_WAIT && !dmem_ack_i) || (state==RUN && dmem_req_i && !dmem_ack_i).
- Priority is mem_hold > load_use > branch_taken_i. Lower-priority events are masked in the same cycle and re-evaluate naturally once the hold releases, because ID/EX and IF/ID hold their contents.
- mem_hold: pc_write_o=0, ifid_stall_o=1, idex_stall_o=1, exmem_stall_o=1, memwb_bubble_o=1; idex_bubble_o=0, ifid_flush_o=0.
- load_use (no mem_hold): pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1; all others 0. Lasts exactly 1 cycle, because the next cycle the load has left ID/EX.
- branch_taken_i (neither of the above): ifid_flush_o=1, pc_write_o=1; all others 0.
- Idle: pc_write_o=1, everything else 0.
- Transitions:
  - RUN -> MEM_WAIT when dmem_req_i && !dmem_ack_i; wait counter set to 1.
  - RUN stays RUN when dmem_ack_i arrives in the same cycle as dmem_req_i (zero-wait access, no stall).
  - MEM_WAIT -> RUN on dmem_ack_i. The ack cycle itself is not a stall cycle; wait counter resets to 0.
  - MEM_WAIT with !dmem_ack_i: wait counter increments, saturating at 255.
- Timeout: when wait counter==MEM_TIMEOUT in MEM_WAIT, mem_timeout_o sets and stays 1 until reset. The FSM keeps waiting; there is no forced exit.
- dmem_req_i dropping while in MEM_WAIT is a protocol violation and is ignored; only dmem_ack_i exits.
- Reset asserted mid-wait returns the FSM to RUN immediately and releases all holds asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt_o increments each cycle in which pc_write_o==0.
  - flush_cnt_o increments each cycle with ifid_flush_o==1.
  - Both counters are saturating at 2^CNT_W-1 and cleared by reset.
- Undefined: both counters are not instantiated and stall_cnt_o/flush_cnt_o are tied to 0.

Test Plan:
- Load-use: idex_memread_i=1, idex_rtaddr_i=8, ifid_rsaddr_i=8 -> exactly 1 cycle of pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. With idex_rtaddr_i=0 -> no stall.
- Branch: branch_taken_i=1 with no hazards -> ifid_flush_o=1 for 1 cycle, pc_write_o=1; flush_cnt_o goes 0->1 with HAZARD_PERF_EN.
- Memory wait: dmem_req_i=1, ack after 3 cycles -> 3 cycles with pc_write_o=0, idex_stall_o=1, exmem_stall_o=1, memwb_bubble_o=1. State returns to RUN on the ack cycle; stall_cnt_o=3.
- Priority: in MEM_WAIT, raise load_use and branch_taken_i together -> only the mem_hold pattern appears. After ack, load_use bubble is issued next cycle.
- Timeout: MEM_TIMEOUT=4, never ack -> mem_timeout_o rises when wait counter=4 and stays high. Holds remain asserted; ack then returns the FSM to RUN with mem_timeout_o still 1.
- Reset mid-wait: assert rst_i during MEM_WAIT -> outputs immediately pc_write_o=1, all holds 0. After release: state RUN, counters 0, mem_timeout_o 0.
